irq_timer: RTL and testbench
============================

IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, is the byte base of the register window.
REQ-002 Register map: TH = BASE+0x0 (reload value), TL = BASE+0x4 (counter), TCON = BASE+0x8 (bit0 EN, bit1 IE, bit2 ST, bits 31:3 read 0).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port addr, input, 32: byte address from the data bus.
REQ-006 Port wdata, input, 32: write data.
REQ-007 Port mem_wr, input, 1: write strobe, sampled at clk.
REQ-008 Port mem_rd, input, 1: read strobe.
REQ-009 Port rdata, output, 32: read data.
REQ-010 Port irq_ack, input, 1: one-cycle pulse from the CPU hazard logic when it redirects the PC to the interrupt vector.
REQ-011 Port irq, output, 1: level interrupt request to the CPU.

Function
REQ-012 A register hits only when addr[31:4]==BASE_ADDR[31:4] and addr[1:0]==0; any other address is ignored on write and returns 0 on read.
REQ-013 rdata is combinational: current register value when mem_rd=1 and the address hits, else 32'h0; zero wait states.
REQ-014 A write takes effect at the clk edge where mem_wr=1; the new value is visible on rdata the following cycle.
REQ-015 Tick: each cycle with EN=1 (and prescaler tick, REQ-025) TL increments by 1, modulo 2^32.
REQ-016 Overflow: a tick with TL==32'hFFFF_FFFF loads TL<=TH instead of incrementing and sets ST if IE=1.
REQ-017 irq = IE & ST, combinational from the registers; no extra latency.
REQ-018 ST clears on irq_ack=1, or on a TCON write with wdata[2]=0; a TCON write with wdata[2]=1 leaves ST unchanged (software cannot set ST).
REQ-019 Same-cycle conflict, set vs clear: an overflow setting ST wins over irq_ack or a software clear.
REQ-020 Same-cycle conflict, write vs tick: a TL write wins over increment and reload; a TH write in the overflow cycle reloads the old TH.
REQ-021 Clearing EN freezes TL and the prescaler at their current values; ST is unaffected.
REQ-022 Clearing IE drops irq the same cycle and blocks further ST sets; a pending ST remains set.

Reset
REQ-023 While rst_n=0, TH, TL, TCON (and PRESC/prescale count when enabled) are 0; irq=0.
REQ-024 Reset deassertion mid-count restarts from zero; no pending interrupt survives reset.

Configuration
REQ-025 With IRQ_TIMER_PRESCALE_EN defined: a 16-bit PRESC register at BASE+0xC (bits 31:16 read 0) is added, and a tick occurs once every PRESC+1 enabled cycles; a PRESC write restarts the prescale count at 0.
REQ-026 Without IRQ_TIMER_PRESCALE_EN: a tick occurs on every enabled cycle, and BASE+0xC reads 0 and ignores writes.

Structure
REQ-027 A shared package irq_timer_pkg holds the register offsets (TH, TL, TCON, PRESC) and the TCON bit indices (EN, IE, ST).
REQ-028 One sub-module, irq_timer_prescaler (16-bit down-counter emitting the tick), is instantiated only under IRQ_TIMER_PRESCALE_EN.

Verification
REQ-029 Scenario, basic overflow: reset; write TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3 -> TL=FFFF_FFFF after 1 cycle, TL=FFFF_FFF0 and irq=1 after 2 cycles.
REQ-030 Scenario, acknowledge: with irq=1, pulse irq_ack for 1 cycle -> irq=0 next cycle, and TL keeps counting from its current value.
REQ-031 Scenario, set wins: irq_ack and overflow in the same cycle -> ST=1 and irq stays 1.
REQ-032 Scenario, write vs tick: with TL=5 counting, write TL=100 -> TL reads 100, then 101 the next cycle.
REQ-033 Scenario, IE off and EN off: TCON=1 through an overflow -> irq stays 0 and ST=0; then TCON=0 -> TL holds constant for 10 cycles.
REQ-034 Scenario, prescaler (macro defined): PRESC=3, TCON=1 -> TL increments once every 4 cycles; assert rst_n=0 mid-count -> all registers read 0 immediately.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// ============================================================================
// Module : irq_timer_pkg
// Brief  : Register offsets and TCON bit positions shared by the irq_timer RTL.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_timer_pkg;

  localparam logic [3:0] OFF_TH    = 4'h0;
  localparam logic [3:0] OFF_TL    = 4'h4;
  localparam logic [3:0] OFF_TCON  = 4'h8;
  localparam logic [3:0] OFF_PRESC = 4'hC;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam int PRESC_W = 16;

endpackage

`default_nettype wire

// File: rtl/irq_timer_prescaler.sv
// ============================================================================
// Module : irq_timer_prescaler
// Brief  : 16-bit down-counter; emits a tick once every reload_i+1 enabled cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_timer_prescaler
  import irq_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [PRESC_W-1:0] load_val_i,
  input  logic [PRESC_W-1:0] reload_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  // Loading the new divisor makes the next tick land PRESC+1 enabled cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = tick_o ? reload_i : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_timer.sv
// ============================================================================
// Module : irq_timer
// Brief  : Memory-mapped 32-bit auto-reload timer with level interrupt.
//          Optional prescaler enabled by defining IRQ_TIMER_PRESCALE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  input  logic        irq_ack,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        st_q, st_d;

  logic w_hit;
  logic w_sel_th, w_sel_tl, w_sel_tcon, w_sel_presc;
  logic w_wr_th, w_wr_tl, w_wr_tcon, w_wr_presc;
  logic w_tick, w_ovf;

  assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign w_sel_th    = w_hit && (addr[3:0] == OFF_TH);
  assign w_sel_tl    = w_hit && (addr[3:0] == OFF_TL);
  assign w_sel_tcon  = w_hit && (addr[3:0] == OFF_TCON);
  assign w_sel_presc = w_hit && (addr[3:0] == OFF_PRESC);

  assign w_wr_th    = mem_wr && w_sel_th;
  assign w_wr_tl    = mem_wr && w_sel_tl;
  assign w_wr_tcon  = mem_wr && w_sel_tcon;
  assign w_wr_presc = mem_wr && w_sel_presc;

`ifdef IRQ_TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               w_presc_tick;

  irq_timer_prescaler u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_q),
    .load_i     (w_wr_presc),
    .load_val_i (wdata[PRESC_W-1:0]),
    .reload_i   (presc_q),
    .tick_o     (w_presc_tick)
  );

  assign w_tick  = w_presc_tick;
  assign presc_d = w_wr_presc ? wdata[PRESC_W-1:0] : presc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic w_unused_presc;
  assign w_unused_presc = w_wr_presc;
  assign w_tick         = en_q;
`endif

  assign w_ovf = w_tick && (tl_q == 32'hFFFF_FFFF);
  assign irq   = ie_q && st_q;

  // Overflow reloads the pre-write TH; a TL write beats both increment and reload.
  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    en_d = en_q;
    ie_d = ie_q;
    st_d = st_q;

    if (w_wr_th) th_d = wdata;

    if (w_wr_tl) begin
      tl_d = wdata;
    end else if (w_tick) begin
      tl_d = w_ovf ? th_q : tl_q + 32'd1;
    end

    if (w_wr_tcon) begin
      en_d = wdata[TCON_EN];
      ie_d = wdata[TCON_IE];
    end

    // Setting beats any clear in the same cycle; software can never set ST.
    if (w_ovf && ie_q) begin
      st_d = 1'b1;
    end else if (irq_ack || (w_wr_tcon && !wdata[TCON_ST])) begin
      st_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q <= '0;
      tl_q <= '0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
      en_q <= en_d;
      ie_q <= ie_d;
      st_q <= st_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (mem_rd) begin
      if (w_sel_th)   rdata = th_q;
      if (w_sel_tl)   rdata = tl_q;
      if (w_sel_tcon) rdata = {29'h0, st_q, ie_q, en_q};
`ifdef IRQ_TIMER_PRESCALE_EN
      if (w_sel_presc) rdata = {{(32-PRESC_W){1'b0}}, presc_q};
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_timer.sv
// ============================================================================
// Module : tb_irq_timer
// Brief  : Self-checking bench for irq_timer (honours IRQ_TIMER_PRESCALE_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE + 32'h0;
  localparam logic [31:0] A_TL = BASE + 32'h4;
  localparam logic [31:0] A_TC = BASE + 32'h8;
  localparam logic [31:0] A_PS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] rdata;
  logic        irq_ack;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_timer #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .mem_wr  (mem_wr),
    .mem_rd  (mem_rd),
    .rdata   (rdata),
    .irq_ack (irq_ack),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Architectural state of the timer as software sees it.
  typedef struct packed {
    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ie;
    logic        st;
    logic [15:0] presc;
    logic [15:0] pcnt;   // enabled cycles elapsed since the last tick
  } model_t;

  model_t m;

  function automatic logic is_reg(input logic [31:0] a, input logic [3:0] off);
    return (a[31:4] == BASE[31:4]) && (a[3:0] == off);
  endfunction

  function automatic model_t step(input model_t s, input logic [31:0] a, input logic [31:0] d,
                                  input logic wr, input logic ack);
    model_t n = s;
    logic   tick;
    logic   ovf;
`ifdef IRQ_TIMER_PRESCALE_EN
    tick = s.en && (s.pcnt == s.presc);
    if (wr && is_reg(a, 4'hC)) begin
      n.presc = d[15:0];
      n.pcnt  = 16'd0;
    end else if (s.en) begin
      n.pcnt = tick ? 16'd0 : s.pcnt + 16'd1;
    end
`else
    tick = s.en;
`endif
    ovf = tick && (s.tl == 32'hFFFF_FFFF);
    if (tick) n.tl = ovf ? s.th : s.tl + 32'd1;
    if (wr && is_reg(a, 4'h4)) n.tl = d;
    if (wr && is_reg(a, 4'h0)) n.th = d;
    if (wr && is_reg(a, 4'h8)) begin
      n.en = d[0];
      n.ie = d[1];
      if (!d[2]) n.st = 1'b0;
    end
    if (ack) n.st = 1'b0;
    if (ovf && s.ie) n.st = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input model_t s, input logic [31:0] a, input logic rd);
    if (!rd) return 32'h0;
    if (is_reg(a, 4'h0)) return s.th;
    if (is_reg(a, 4'h4)) return s.tl;
    if (is_reg(a, 4'h8)) return {29'h0, s.st, s.ie, s.en};
`ifdef IRQ_TIMER_PRESCALE_EN
    if (is_reg(a, 4'hC)) return {16'h0, s.presc};
`endif
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, addr, wdata, mem_wr, irq_ack);
  end

  always @(negedge clk) begin
    n_checks = n_checks + 2;
    if (irq !== (m.ie && m.st)) begin
      n_fail = n_fail + 1;
      $display("FAIL model_irq t=%0t got %b expected %b", $time, irq, m.ie && m.st);
    end
    if (rdata !== exp_rd(m, addr, mem_rd)) begin
      n_fail = n_fail + 1;
      $display("FAIL model_rdata t=%0t addr=%h got %h expected %h", $time, addr, rdata,
               exp_rd(m, addr, mem_rd));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wdata  = d;
    mem_wr = 1'b1;
    cyc();
    mem_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr   = a;
    mem_rd = 1'b1;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; addr = A_TL; wdata = '0; mem_wr = 1'b0; mem_rd = 1'b1; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("rst_th", A_TH, 32'h0);
    rd_chk("rst_tl", A_TL, 32'h0);
    rd_chk("rst_tcon", A_TC, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // basic overflow
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    rd_chk("ovf_tl0", A_TL, 32'hFFFF_FFFE);
    cyc();
    rd_chk("ovf_tl1", A_TL, 32'hFFFF_FFFF);
    chk("ovf_irq_pre", {31'h0, irq}, 32'h0);
    cyc();
    rd_chk("ovf_reload", A_TL, 32'hFFFF_FFF0);
    chk("ovf_irq", {31'h0, irq}, 32'h1);

    // acknowledge
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("ack_irq", {31'h0, irq}, 32'h0);
    rd_chk("ack_tl", A_TL, 32'hFFFF_FFF1);

    // set beats ack in the same cycle
    wr(A_TL, 32'hFFFF_FFFE);
    cyc();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
    chk("setwin_irq", {31'h0, irq}, 32'h1);
    rd_chk("setwin_tl", A_TL, 32'hFFFF_FFF0);

    // software cannot set ST; writing ST=0 clears it
    wr(A_TC, 32'h7);
    chk("sw_keep_irq", {31'h0, irq}, 32'h1);
    wr(A_TC, 32'h3);
    chk("sw_clr_irq", {31'h0, irq}, 32'h0);
    wr(A_TC, 32'h7);
    rd_chk("sw_noset", A_TC, 32'h3);

    // TL write beats increment
    wr(A_TL, 32'd5);
    wr(A_TL, 32'd100);
    rd_chk("wr_tl100", A_TL, 32'd100);
    cyc();
    rd_chk("wr_tl101", A_TL, 32'd101);

    // IE off through an overflow, then EN off freezes TL
    wr(A_TC, 32'h1);
    wr(A_TL, 32'hFFFF_FFFE);
    cyc();
    cyc();
    rd_chk("ieoff_tl", A_TL, 32'hFFFF_FFF0);
    rd_chk("ieoff_tcon", A_TC, 32'h1);
    chk("ieoff_irq", {31'h0, irq}, 32'h0);
    wr(A_TC, 32'h0);
    for (int i = 0; i < 10; i++) begin
      rd_chk("enoff_hold", A_TL, 32'hFFFF_FFF1);
      cyc();
    end

    // clearing IE hides a pending ST without losing it
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    cyc();
    chk("pend_irq", {31'h0, irq}, 32'h1);
    wr(A_TC, 32'h5);
    chk("ie_drop_irq", {31'h0, irq}, 32'h0);
    rd_chk("ie_drop_tcon", A_TC, 32'h5);
    wr(A_TC, 32'h7);
    chk("ie_back_irq", {31'h0, irq}, 32'h1);
    wr(A_TC, 32'h0);

    // address decoding
    wr(BASE + 32'h10, 32'hDEAD_BEEF);
    wr(BASE + 32'h1, 32'h1234_5678);
    wr(32'h5000_0000, 32'h0BAD_F00D);
    rd_chk("dec_th", A_TH, 32'hFFFF_FFF0);
    rd_chk("dec_miss10", BASE + 32'h10, 32'h0);
    rd_chk("dec_misalign", BASE + 32'h1, 32'h0);
    addr = A_TH; mem_rd = 1'b0; #1;
    chk("dec_nord", rdata, 32'h0);
    mem_rd = 1'b1;

`ifdef IRQ_TIMER_PRESCALE_EN
    wr(A_PS, 32'hABCD_0003);
    rd_chk("ps_rd", A_PS, 32'h0000_0003);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      rd_chk("ps_hold", A_TL, 32'h0);
    end
    cyc();
    rd_chk("ps_tick1", A_TL, 32'h1);
    repeat (4) cyc();
    rd_chk("ps_tick2", A_TL, 32'h2);
`else
    wr(A_PS, 32'h0000_1234);
    rd_chk("ps_absent", A_PS, 32'h0);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    repeat (3) cyc();
    rd_chk("noprs_tl", A_TL, 32'h3);
`endif

    // asynchronous reset mid-count
    wr(A_TC, 32'h3);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    rd_chk("arst_th", A_TH, 32'h0);
    rd_chk("arst_tl", A_TL, 32'h0);
    rd_chk("arst_tcon", A_TC, 32'h0);
    rd_chk("arst_ps", A_PS, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    rd_chk("post_rst_tl", A_TL, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
